// File: rtl/ex_wb_stage_pkg.sv
// Shared constants and ALU op encodings for the EX/WB stage.
// Widths here are the defaults for the stage and ALU parameters.
package ex_wb_stage_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned REG_AW = 3;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

endpackage

// File: rtl/alu8.sv
// Combinational ALU: ADD/SUB with carry/borrow, AND/OR with carry cleared.
module alu8 #(
   parameter int unsigned DATA_W = ex_wb_stage_pkg::DATA_W
) (
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] result_o,
   output logic              carry_o
);
   import ex_wb_stage_pkg::*;

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   assign sum  = {1'b0, a_i} + {1'b0, b_i};
   // The extra MSB of the 9-bit difference is set exactly when a_i < b_i.
   assign diff = {1'b0, a_i} - {1'b0, b_i};

   always_comb begin
      result_o = '0;
      carry_o  = 1'b0;
      case (alu_op_e'(op_i))
         ALU_ADD: begin
            result_o = sum[DATA_W-1:0];
            carry_o  = sum[DATA_W];
         end
         ALU_SUB: begin
            result_o = diff[DATA_W-1:0];
            carry_o  = diff[DATA_W];
         end
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         default: begin
            result_o = '0;
            carry_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute stage: WB-to-EX forwarding on rs, ALU or immediate select, EX/WB register,
// registered zero/carry flags and a saturating forwarding-event counter.
module ex_wb_stage #(
   parameter int unsigned DATA_W = ex_wb_stage_pkg::DATA_W,
   parameter int unsigned REG_AW = ex_wb_stage_pkg::REG_AW,
   parameter int unsigned CNT_W  = ex_wb_stage_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              reg_write_idex,
   input  logic [1:0]        alu_ctrl_idex,
   input  logic [DATA_W-1:0] data1_idex,
   input  logic [DATA_W-1:0] data2_idex,
   input  logic [REG_AW-1:0] rd_idex,
   input  logic              output_sel_idex,
   input  logic [REG_AW-1:0] rs_idex,
   output logic              reg_write_exwb,
   output logic [REG_AW-1:0] rd_exwb,
   output logic [DATA_W-1:0] wb_data_exwb,
   output logic              zero_flag,
   output logic              carry_flag,
   output logic [CNT_W-1:0]  fwd_count
);

   logic              reg_write_q, reg_write_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              zero_q, zero_d;
   logic              carry_q, carry_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              fwd_hit;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] alu_res;
   logic              alu_carry;
   logic              flag_upd;

   // A bubble (write-enable low) never forwards; r0 is an ordinary register here.
   assign fwd_hit = reg_write_q && (rd_q == rs_idex);
   assign op_a    = fwd_hit ? wb_data_q : data1_idex;

   alu8 #(
      .DATA_W (DATA_W)
   ) u_alu (
      .op_i     (alu_ctrl_idex),
      .a_i      (op_a),
      .b_i      (data2_idex),
      .result_o (alu_res),
      .carry_o  (alu_carry)
   );

   assign flag_upd = reg_write_idex && !output_sel_idex && !flush;

   always_comb begin
      reg_write_d = reg_write_idex & ~flush;
      rd_d        = rd_idex;
      wb_data_d   = output_sel_idex ? data2_idex : alu_res;
      zero_d      = zero_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      if (flag_upd) begin
         zero_d  = (alu_res == '0);
         carry_d = alu_carry;
      end
      if (fwd_hit && !flush && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_q <= 1'b0;
         rd_q        <= '0;
         wb_data_q   <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         reg_write_q <= reg_write_d;
         rd_q        <= rd_d;
         wb_data_q   <= wb_data_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
      end
   end

   assign reg_write_exwb = reg_write_q;
   assign rd_exwb        = rd_q;
   assign wb_data_exwb   = wb_data_q;
   assign zero_flag      = zero_q;
   assign carry_flag     = carry_q;
   assign fwd_count      = cnt_q;

endmodule
